// File: rtl/exec_ctrl_pkg.sv
// Shared encodings for the run/step/halt sequencer: FSM states and halt cause codes.
package exec_ctrl_pkg;

    localparam int STATE_W = 3;
    localparam int CAUSE_W = 2;

    localparam logic [STATE_W-1:0] S_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] S_LOAD = 3'd1;
    localparam logic [STATE_W-1:0] S_STEP = 3'd2;
    localparam logic [STATE_W-1:0] S_RUN  = 3'd3;
    localparam logic [STATE_W-1:0] S_HALT = 3'd4;

    localparam logic [CAUSE_W-1:0] CAUSE_NONE = 2'd0;
    localparam logic [CAUSE_W-1:0] CAUSE_EXC  = 2'd1;
    localparam logic [CAUSE_W-1:0] CAUSE_BRK  = 2'd2;
    localparam logic [CAUSE_W-1:0] CAUSE_USER = 2'd3;

endpackage

// File: rtl/exec_controller_rise_detect.sv
// Button conditioner: one register stage, then a one-cycle pulse on each rising edge.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic req
);

    logic btn_q;
    logic btn_qq;
    logic armed;

    // armed stays low until the raw button is seen released, so a press held through reset is ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q  <= 1'b0;
            btn_qq <= 1'b0;
            armed  <= 1'b0;
        end else begin
            btn_q  <= btn;
            btn_qq <= btn_q;
            armed  <= armed | ~btn;
        end
    end

    assign req = btn_q & ~btn_qq & armed;

endmodule

// File: rtl/exec_controller.sv
// Run/step/halt sequencer driving the CPU clock enable and PC-load strobe.
// Define EXEC_CTRL_BREAKPOINT_EN to enable the PC breakpoint comparator.
module exec_controller
    import exec_ctrl_pkg::*;
#(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic               SYS_clk,
    input  logic               SYS_reset,
    input  logic               run_btn,
    input  logic               step_btn,
    input  logic               halt_btn,
    input  logic               load_btn,
    input  logic [PC_W-1:0]    load_pc,
    input  logic               bp_en,
    input  logic [PC_W-1:0]    bp_addr,
    input  logic [PC_W-1:0]    cpu_pc,
    input  logic               cpu_exc,
    output logic               cpu_en,
    output logic               cpu_load,
    output logic [PC_W-1:0]    cpu_pc_val,
    output logic [STATE_W-1:0] state,
    output logic [CAUSE_W-1:0] halt_cause,
    output logic [PC_W-1:0]    epc,
    output logic [CNT_W-1:0]   instr_cnt
);

    logic run_req;
    logic step_req;
    logic halt_req;
    logic load_req;
    logic bp_hit;

    logic [STATE_W-1:0] state_next;
    logic [CAUSE_W-1:0] cause_next;
    logic [PC_W-1:0]    epc_next;
    logic [PC_W-1:0]    pcv_next;
    logic               count_en;

    rise_detect u_run  (.clk(SYS_clk), .reset(SYS_reset), .btn(run_btn),  .req(run_req));
    rise_detect u_step (.clk(SYS_clk), .reset(SYS_reset), .btn(step_btn), .req(step_req));
    rise_detect u_halt (.clk(SYS_clk), .reset(SYS_reset), .btn(halt_btn), .req(halt_req));
    rise_detect u_load (.clk(SYS_clk), .reset(SYS_reset), .btn(load_btn), .req(load_req));

`ifdef EXEC_CTRL_BREAKPOINT_EN
    logic first_run;

    // High during the first RUN cycle so resuming from a breakpoint PC steps past it
    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) first_run <= 1'b0;
        else           first_run <= (state != S_RUN);
    end

    assign bp_hit = bp_en && (cpu_pc == bp_addr) && !first_run;
`else
    logic unused_bp;
    assign unused_bp = &{1'b0, bp_en, bp_addr};
    assign bp_hit    = 1'b0;
`endif

    always_comb begin
        state_next = state;
        cause_next = halt_cause;
        epc_next   = epc;
        pcv_next   = cpu_pc_val;
        cpu_en     = 1'b0;
        cpu_load   = 1'b0;
        case (state)
            S_IDLE: begin
                if (halt_req) begin
                    cause_next = CAUSE_USER;
                end else if (load_req) begin
                    state_next = S_LOAD;
                    pcv_next   = load_pc;
                end else if (step_req) begin
                    state_next = S_STEP;
                end else if (run_req) begin
                    state_next = S_RUN;
                end
            end
            S_LOAD: begin
                cpu_en     = 1'b1;
                cpu_load   = 1'b1;
                cause_next = CAUSE_NONE;
                state_next = S_IDLE;
            end
            S_STEP: begin
                cpu_en     = 1'b1;
                state_next = S_IDLE;
                if (cpu_exc) begin
                    epc_next   = cpu_pc;
                    cause_next = CAUSE_EXC;
                    state_next = S_HALT;
                end
            end
            S_RUN: begin
                if (halt_req) begin
                    cause_next = CAUSE_USER;
                    state_next = S_IDLE;
                end else if (bp_hit) begin
                    cause_next = CAUSE_BRK;
                    state_next = S_HALT;
                end else begin
                    // The excepting instruction still retires; the CPU masks its side effects
                    cpu_en = 1'b1;
                    if (cpu_exc) begin
                        epc_next   = cpu_pc;
                        cause_next = CAUSE_EXC;
                        state_next = S_HALT;
                    end
                end
            end
            S_HALT: begin
                if (!halt_req && load_req) begin
                    state_next = S_LOAD;
                    pcv_next   = load_pc;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign count_en = cpu_en && !cpu_load;

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            state      <= S_IDLE;
            halt_cause <= CAUSE_NONE;
            epc        <= '0;
            cpu_pc_val <= '0;
            instr_cnt  <= '0;
        end else begin
            state      <= state_next;
            halt_cause <= cause_next;
            epc        <= epc_next;
            cpu_pc_val <= pcv_next;
            if (count_en && (instr_cnt != '1))
                instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_exec_controller.sv
// Directed bench for exec_controller with a queued expectation scoreboard and a tiny PC model.
module tb_exec_controller;
    import exec_ctrl_pkg::*;

    localparam int SIG_STATE = 0;
    localparam int SIG_EN    = 1;
    localparam int SIG_LOAD  = 2;
    localparam int SIG_PCV   = 3;
    localparam int SIG_CAUSE = 4;
    localparam int SIG_EPC   = 5;
    localparam int SIG_CNT   = 6;
    localparam int SIG_CNT4  = 7;

    logic       SYS_clk = 1'b0;
    logic       SYS_reset;
    logic       run_btn, step_btn, halt_btn, load_btn;
    logic [7:0] load_pc, bp_addr, cpu_pc;
    logic       bp_en, cpu_exc;

    logic        cpu_en, cpu_load;
    logic [7:0]  cpu_pc_val, epc;
    logic [2:0]  state;
    logic [1:0]  halt_cause;
    logic [15:0] instr_cnt;

    logic        cpu_en4, cpu_load4;
    logic [7:0]  cpu_pc_val4, epc4;
    logic [2:0]  state4;
    logic [1:0]  halt_cause4;
    logic [3:0]  instr_cnt4;

    exec_controller #(.PC_W(8), .CNT_W(16)) u_dut (
        .SYS_clk(SYS_clk), .SYS_reset(SYS_reset),
        .run_btn(run_btn), .step_btn(step_btn), .halt_btn(halt_btn), .load_btn(load_btn),
        .load_pc(load_pc), .bp_en(bp_en), .bp_addr(bp_addr),
        .cpu_pc(cpu_pc), .cpu_exc(cpu_exc),
        .cpu_en(cpu_en), .cpu_load(cpu_load), .cpu_pc_val(cpu_pc_val), .state(state),
        .halt_cause(halt_cause), .epc(epc), .instr_cnt(instr_cnt)
    );

    exec_controller #(.PC_W(8), .CNT_W(4)) u_dut4 (
        .SYS_clk(SYS_clk), .SYS_reset(SYS_reset),
        .run_btn(run_btn), .step_btn(step_btn), .halt_btn(halt_btn), .load_btn(load_btn),
        .load_pc(load_pc), .bp_en(bp_en), .bp_addr(bp_addr),
        .cpu_pc(cpu_pc), .cpu_exc(cpu_exc),
        .cpu_en(cpu_en4), .cpu_load(cpu_load4), .cpu_pc_val(cpu_pc_val4), .state(state4),
        .halt_cause(halt_cause4), .epc(epc4), .instr_cnt(instr_cnt4)
    );

    always #5 SYS_clk = ~SYS_clk;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   exc_arm = 1'b0;
    logic [7:0] exc_pc = 8'h00;
    int   en_cycles;

    function automatic logic [31:0] observe(int sig);
        case (sig)
            SIG_STATE: return 32'(state);
            SIG_EN:    return 32'(cpu_en);
            SIG_LOAD:  return 32'(cpu_load);
            SIG_PCV:   return 32'(cpu_pc_val);
            SIG_CAUSE: return 32'(halt_cause);
            SIG_EPC:   return 32'(epc);
            SIG_CNT:   return 32'(instr_cnt);
            SIG_CNT4:  return 32'(instr_cnt4);
            default:   return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sig, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.sig = sig; e.exp = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = observe(e.sig);
            checks++;
            assert (o === e.exp) else begin
                errors++;
                $error("FAIL %s: observed=0x%0h expected=0x%0h", e.tag, o, e.exp);
            end
        end
    endtask

    task automatic check_now(input string tag, input logic [31:0] o, input logic [31:0] v);
        checks++;
        assert (o === v) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, o, v);
        end
    endtask

    // CPU stand-in: PC loads on cpu_load, otherwise advances by 4 when enabled
    task automatic tick(input int n = 1);
        logic       en, ld;
        logic [7:0] pv;
        for (int i = 0; i < n; i++) begin
            @(negedge SYS_clk);
            en = cpu_en; ld = cpu_load; pv = cpu_pc_val;
            @(posedge SYS_clk);
            #1;
            if (ld)      cpu_pc = pv;
            else if (en) cpu_pc = cpu_pc + 8'd4;
            cpu_exc = exc_arm && (cpu_pc == exc_pc);
            #1;
        end
    endtask

    initial begin
        SYS_reset = 1'b1;
        run_btn = 1'b0; step_btn = 1'b0; halt_btn = 1'b0; load_btn = 1'b0;
        load_pc = 8'h00; bp_en = 1'b0; bp_addr = 8'h00; cpu_pc = 8'h00; cpu_exc = 1'b0;
        tick(2);
        expect_val("rst_state", SIG_STATE, 32'(S_IDLE));
        expect_val("rst_en",    SIG_EN,    0);
        expect_val("rst_load",  SIG_LOAD,  0);
        expect_val("rst_pcv",   SIG_PCV,   0);
        expect_val("rst_cause", SIG_CAUSE, 0);
        expect_val("rst_epc",   SIG_EPC,   0);
        expect_val("rst_cnt",   SIG_CNT,   0);
        drain();
        SYS_reset = 1'b0;
        tick(2);

        // halt request while idle records a user halt
        halt_btn = 1'b1; tick(); halt_btn = 1'b0; tick();
        expect_val("idle_halt_state", SIG_STATE, 32'(S_IDLE));
        expect_val("idle_halt_cause", SIG_CAUSE, 32'(CAUSE_USER));
        drain();

        // PC load of 0x10
        load_pc = 8'h10; load_btn = 1'b1; tick();
        expect_val("load_lat1", SIG_LOAD, 0);
        drain();
        load_btn = 1'b0; tick();
        expect_val("load_strobe", SIG_LOAD,  1);
        expect_val("load_en",     SIG_EN,    1);
        expect_val("load_state",  SIG_STATE, 32'(S_LOAD));
        expect_val("load_pcv",    SIG_PCV,   32'h10);
        drain();
        tick();
        expect_val("load_done",  SIG_LOAD,  0);
        expect_val("load_idle",  SIG_STATE, 32'(S_IDLE));
        expect_val("load_cnt",   SIG_CNT,   0);
        expect_val("load_clear", SIG_CAUSE, 32'(CAUSE_NONE));
        drain();

        // step button held for 10 cycles gives exactly one enabled cycle
        step_btn = 1'b1; en_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cpu_en) en_cycles++;
        end
        step_btn = 1'b0; tick();
        check_now("step_en_cycles", 32'(en_cycles), 1);
        expect_val("step_cnt",   SIG_CNT,   1);
        expect_val("step_cnt4",  SIG_CNT4,  1);
        expect_val("step_state", SIG_STATE, 32'(S_IDLE));
        drain();

        // reload PC 0, run until exception at 0x0C
        load_pc = 8'h00; load_btn = 1'b1; tick(); load_btn = 1'b0; tick(2);
        exc_arm = 1'b1; exc_pc = 8'h0C;
        run_btn = 1'b1; tick(); run_btn = 1'b0; tick();
        expect_val("run_state", SIG_STATE, 32'(S_RUN));
        expect_val("run_en",    SIG_EN,    1);
        drain();
        tick(3);
        check_now("exc_pc_model", 32'(cpu_pc), 32'h0C);
        expect_val("exc_en",    SIG_EN,    1);
        expect_val("exc_state", SIG_STATE, 32'(S_RUN));
        drain();
        tick();
        exc_arm = 1'b0;
        expect_val("exc_halt",  SIG_STATE, 32'(S_HALT));
        expect_val("exc_cause", SIG_CAUSE, 32'(CAUSE_EXC));
        expect_val("exc_epc",   SIG_EPC,   32'h0C);
        expect_val("exc_cnt",   SIG_CNT,   5);
        expect_val("exc_cnt4",  SIG_CNT4,  5);
        expect_val("halt_en",   SIG_EN,    0);
        drain();

        // run and step ignored in HALT
        run_btn = 1'b1; tick(); run_btn = 1'b0; tick(2);
        step_btn = 1'b1; tick(); step_btn = 1'b0; tick(2);
        expect_val("halt_ign_state", SIG_STATE, 32'(S_HALT));
        expect_val("halt_ign_en",    SIG_EN,    0);
        expect_val("halt_ign_cause", SIG_CAUSE, 32'(CAUSE_EXC));
        expect_val("halt_ign_cnt",   SIG_CNT,   5);
        drain();

        // load leaves HALT and clears the cause
        load_pc = 8'h00; load_btn = 1'b1; tick(); load_btn = 1'b0; tick();
        expect_val("halt_load_state", SIG_STATE, 32'(S_LOAD));
        expect_val("halt_load_strb",  SIG_LOAD,  1);
        drain();
        tick();
        expect_val("halt_load_idle",  SIG_STATE, 32'(S_IDLE));
        expect_val("halt_load_cause", SIG_CAUSE, 32'(CAUSE_NONE));
        expect_val("halt_load_epc",   SIG_EPC,   32'h0C);
        expect_val("halt_load_cnt",   SIG_CNT,   5);
        drain();

        // breakpoint at 0x08 under RUN from PC 0
        bp_en = 1'b1; bp_addr = 8'h08;
        run_btn = 1'b1; tick(); run_btn = 1'b0; tick(3);
        check_now("bp_pc_model", 32'(cpu_pc), 32'h08);
`ifdef EXEC_CTRL_BREAKPOINT_EN
        expect_val("bp_en_off", SIG_EN, 0);
        drain();
        tick();
        expect_val("bp_state", SIG_STATE, 32'(S_HALT));
        expect_val("bp_cause", SIG_CAUSE, 32'(CAUSE_BRK));
        expect_val("bp_cnt",   SIG_CNT,   7);
        drain();
        load_pc = 8'h08; load_btn = 1'b1; tick(); load_btn = 1'b0; tick(2);
        run_btn = 1'b1; tick(); run_btn = 1'b0; tick();
        expect_val("bp_resume_en",    SIG_EN,    1);
        expect_val("bp_resume_state", SIG_STATE, 32'(S_RUN));
        drain();
        tick();
`else
        expect_val("nobp_en", SIG_EN, 1);
        drain();
        tick();
`endif
        expect_val("past_bp_state", SIG_STATE, 32'(S_RUN));
        expect_val("past_bp_en",    SIG_EN,    1);
        expect_val("past_bp_cnt",   SIG_CNT,   8);
        expect_val("past_bp_cnt4",  SIG_CNT4,  8);
        drain();

        // halt and load edges together during RUN: halt wins
        halt_btn = 1'b1; load_btn = 1'b1; load_pc = 8'h40; tick();
        expect_val("coin_en",   SIG_EN,   0);
        expect_val("coin_load", SIG_LOAD, 0);
        drain();
        halt_btn = 1'b0; load_btn = 1'b0; tick();
        expect_val("coin_state", SIG_STATE, 32'(S_IDLE));
        expect_val("coin_cause", SIG_CAUSE, 32'(CAUSE_USER));
        expect_val("coin_load2", SIG_LOAD,  0);
        expect_val("coin_cnt",   SIG_CNT,   9);
        drain();
        tick();
        expect_val("coin_load3", SIG_LOAD, 0);
`ifdef EXEC_CTRL_BREAKPOINT_EN
        expect_val("coin_pcv", SIG_PCV, 32'h08);
`else
        expect_val("coin_pcv", SIG_PCV, 32'h00);
`endif
        drain();

        // long run to 37, narrow counter saturates at 15
        bp_en = 1'b0;
        run_btn = 1'b1; tick(); run_btn = 1'b0; tick();
        tick(28);
        expect_val("long_cnt",   SIG_CNT,   37);
        expect_val("long_cnt4",  SIG_CNT4,  15);
        expect_val("long_state", SIG_STATE, 32'(S_RUN));
        drain();

        // reset mid-RUN with run button held through it
        SYS_reset = 1'b1; run_btn = 1'b1; tick();
        expect_val("mid_rst_state", SIG_STATE, 32'(S_IDLE));
        expect_val("mid_rst_en",    SIG_EN,    0);
        expect_val("mid_rst_load",  SIG_LOAD,  0);
        expect_val("mid_rst_pcv",   SIG_PCV,   0);
        expect_val("mid_rst_cause", SIG_CAUSE, 0);
        expect_val("mid_rst_epc",   SIG_EPC,   0);
        expect_val("mid_rst_cnt",   SIG_CNT,   0);
        expect_val("mid_rst_cnt4",  SIG_CNT4,  0);
        drain();
        SYS_reset = 1'b0; tick(4);
        expect_val("held_state", SIG_STATE, 32'(S_IDLE));
        expect_val("held_en",    SIG_EN,    0);
        drain();
        run_btn = 1'b0; tick(); run_btn = 1'b1; tick(); run_btn = 1'b0; tick();
        expect_val("repress_state", SIG_STATE, 32'(S_RUN));
        drain();
        halt_btn = 1'b1; tick(); halt_btn = 1'b0; tick();
        expect_val("final_state", SIG_STATE, 32'(S_IDLE));
        expect_val("final_cause", SIG_CAUSE, 32'(CAUSE_USER));
        expect_val("final_cnt",   SIG_CNT,   1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
